max_run_detector: RTL and testbench

Serial-bit run-length analyser. Scans a frame of FRAME_LEN valid-qualified bits on din and reports the longest run of the pattern selected by mode, plus the index of the bit that ends that run. It is a parametrised, handshaked successor to the single-mode alternating-run detector. It sits on a serial test or data path and feeds status to a host or scoreboard.

---
 rtl/max_run_detector_if.sv | 26 ++
 rtl/max_run_detector.sv | 94 +++++++++
 tb/tb_max_run_detector.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/max_run_detector_if.sv
// Control/result bundle for max_run_detector: frame start, mode select, qualified serial bit in, status out.
// The master modport drives the frame and samples, and the slave modport reports the result.
interface max_run_detector_if #(
  parameter int CNT_W = 5,
  parameter int IDX_W = 5
);
  logic             start;
  logic [1:0]       mode;
  logic             din_valid;
  logic             din;
  logic             busy;
  logic             done;
  logic             result_valid;
  logic [CNT_W-1:0] max_len;
  logic [IDX_W-1:0] max_end_idx;

  modport master (
    output start, mode, din_valid, din,
    input  busy, done, result_valid, max_len, max_end_idx
  );

  modport slave (
    input  start, mode, din_valid, din,
    output busy, done, result_valid, max_len, max_end_idx
  );
endinterface

// File: rtl/max_run_detector.sv
// Longest-run analyser over a FRAME_LEN-sample frame. done follows the final accepted sample by 1 cycle.
// din_valid low stalls the frame. start aborts or re-arms at any time, and a sample in the start cycle is dropped.
module max_run_detector #(
  parameter int CNT_W     = 5,
  parameter int FRAME_LEN = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  max_run_detector_if.slave   bus
);
  localparam int IDX_W = $clog2(FRAME_LEN);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [1:0]       mode_q;
  logic [IDX_W-1:0] idx_q;
  logic [CNT_W-1:0] cur_q, cur_d, cur_inc;
  logic [CNT_W-1:0] max_q;
  logic [IDX_W-1:0] end_q;
  logic             prev_q;
  logic             done_q;
  logic             accept;
  logic             last;
  logic             first;

  assign accept  = (state_q == RUN) && bus.din_valid && !bus.start;
  assign last    = (idx_q == LAST_IDX);
  assign first   = (idx_q == '0);
  assign cur_inc = (cur_q == CNT_MAX) ? cur_q : cur_q + CNT_ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.start)            state_d = RUN;
    else if (accept && last)  state_d = DONE;
  end

  // Run length after the sample being accepted this cycle.
  always_comb begin
    cur_d = cur_q;
    unique case (mode_q)
      2'b00: cur_d = first ? CNT_ONE : ((bus.din != prev_q) ? cur_inc : CNT_ONE);
      2'b01: cur_d = bus.din  ? cur_inc : '0;
      2'b10: cur_d = !bus.din ? cur_inc : '0;
      2'b11: cur_d = first ? CNT_ONE : ((bus.din == prev_q) ? cur_inc : CNT_ONE);
      default: cur_d = cur_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= '0;
      idx_q  <= '0;
      cur_q  <= '0;
      max_q  <= '0;
      end_q  <= '0;
      prev_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= accept && last;
      if (bus.start) begin
        mode_q <= bus.mode;
        idx_q  <= '0;
        cur_q  <= '0;
        max_q  <= '0;
        end_q  <= '0;
      end else if (accept) begin
        cur_q  <= cur_d;
        prev_q <= bus.din;
        if (!last) idx_q <= idx_q + IDX_W'(1);
        // Strict compare keeps the earliest of equal runs and freezes the index once saturated.
        if (cur_d > max_q) begin
          max_q <= cur_d;
          end_q <= idx_q;
        end
      end
    end
  end

  assign bus.busy         = (state_q == RUN);
  assign bus.done         = done_q;
  assign bus.result_valid = (state_q == DONE);
  assign bus.max_len      = max_q;
  assign bus.max_end_idx  = end_q;
endmodule

// File: tb/tb_max_run_detector.sv
// Directed bench: dut_a (CNT_W=4) and dut_b (CNT_W=2), both FRAME_LEN=8, share one stimulus stream.
module tb_max_run_detector;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [1:0] mode;
  logic       din_valid;
  logic       din;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  max_run_detector_if #(.CNT_W(4), .IDX_W(3)) if_a ();
  max_run_detector_if #(.CNT_W(2), .IDX_W(3)) if_b ();

  assign if_a.start = start;  assign if_a.mode = mode;
  assign if_a.din_valid = din_valid;  assign if_a.din = din;
  assign if_b.start = start;  assign if_b.mode = mode;
  assign if_b.din_valid = din_valid;  assign if_b.din = din;

  max_run_detector #(.CNT_W(4), .FRAME_LEN(8)) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  max_run_detector #(.CNT_W(2), .FRAME_LEN(8)) dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [1:0] m);
    start = 1'b1;
    mode  = m;
    tick();
    start = 1'b0;
  endtask

  task automatic smp(input logic b);
    din_valid = 1'b1;
    din       = b;
    tick();
    din_valid = 1'b0;
  endtask

  task automatic stream(input logic [7:0] bits, input int n);
    for (int i = 0; i < n; i++) smp(bits[7-i]);
  endtask

  int gaps [8] = '{2, 1, 3, 0, 2, 1, 2, 1};
  logic [7:0] s2 = 8'b1101_1100;

  initial begin
    rst_n = 1'b0; start = 1'b0; mode = 2'b00; din_valid = 1'b0; din = 1'b0;
    tick(); tick();
    chk("rst_busy", if_a.busy, 0);
    chk("rst_done", if_a.done, 0);
    chk("rst_rv", if_a.result_valid, 0);
    chk("rst_max", if_a.max_len, 0);
    chk("rst_idx", if_a.max_end_idx, 0);
    rst_n = 1'b1;
    tick();

    // Alternating bits, tie between idx 3 and idx 7
    do_start(2'b00);
    chk("t1_busy", if_a.busy, 1);
    stream(8'b0101_1010, 7);
    chk("t1_early_done", if_a.done, 0);
    chk("t1_early_busy", if_a.busy, 1);
    smp(1'b0);
    chk("t1_done", if_a.done, 1);
    chk("t1_busy_fall", if_a.busy, 0);
    chk("t1_rv", if_a.result_valid, 1);
    chk("t1_max", if_a.max_len, 4);
    chk("t1_idx", if_a.max_end_idx, 3);
    tick();
    chk("t1_done_pulse", if_a.done, 0);
    chk("t1_rv_hold", if_a.result_valid, 1);
    chk("t1_max_hold", if_a.max_len, 4);

    // Runs of 1s then runs of 0s on the same stream
    do_start(2'b01);
    chk("t2_rv_clr", if_a.result_valid, 0);
    chk("t2_max_clr", if_a.max_len, 0);
    stream(s2, 8);
    chk("t2a_max", if_a.max_len, 3);
    chk("t2a_idx", if_a.max_end_idx, 5);
    do_start(2'b10);
    stream(s2, 8);
    chk("t2b_max", if_a.max_len, 2);
    chk("t2b_idx", if_a.max_end_idx, 7);

    // Equal bits, eight 0s: dut_b saturates at 3
    do_start(2'b11);
    stream(8'b0000_0000, 8);
    chk("t3_b_max", if_b.max_len, 3);
    chk("t3_b_idx", if_b.max_end_idx, 2);
    chk("t3_b_rv", if_b.result_valid, 1);
    chk("t3_a_max", if_a.max_len, 8);
    chk("t3_a_idx", if_a.max_end_idx, 7);

    // Stalled stream (60% of cycles idle)
    do_start(2'b01);
    for (int i = 0; i < 8; i++) begin
      repeat (gaps[i]) tick();
      chk("t4_busy", if_a.busy, 1);
      chk("t4_no_done", if_a.done, 0);
      smp(s2[7-i]);
    end
    chk("t4_done", if_a.done, 1);
    chk("t4_max", if_a.max_len, 3);
    chk("t4_idx", if_a.max_end_idx, 5);

    // Abort frame A after 4 samples, then full frame B of 1s
    do_start(2'b10);
    stream(8'b0000_0000, 4);
    do_start(2'b01);
    chk("t5_restart_busy", if_a.busy, 1);
    chk("t5_restart_max", if_a.max_len, 0);
    stream(8'b1111_1111, 7);
    chk("t5_no_done_a", if_a.done, 0);
    smp(1'b1);
    chk("t5_done", if_a.done, 1);
    chk("t5_max", if_a.max_len, 8);
    chk("t5_idx", if_a.max_end_idx, 7);

    // Sample presented with start must be dropped
    start = 1'b1; mode = 2'b01; din_valid = 1'b1; din = 1'b1;
    tick();
    start = 1'b0; din_valid = 1'b0;
    stream(8'b1000_0000, 7);
    chk("t5s_no_done", if_a.done, 0);
    smp(1'b0);
    chk("t5s_done", if_a.done, 1);
    chk("t5s_max", if_a.max_len, 1);
    chk("t5s_idx", if_a.max_end_idx, 0);

    // Asynchronous reset mid-frame
    do_start(2'b01);
    stream(8'b1110_0000, 3);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_busy", if_a.busy, 0);
    chk("t6_max", if_a.max_len, 0);
    chk("t6_idx", if_a.max_end_idx, 0);
    chk("t6_rv", if_a.result_valid, 0);
    chk("t6_done", if_a.done, 0);
    #2 rst_n = 1'b1;
    tick();
    stream(8'b1111_1111, 8);
    stream(8'b1111_1111, 2);
    chk("t6_ign_busy", if_a.busy, 0);
    chk("t6_ign_done", if_a.done, 0);
    chk("t6_ign_rv", if_a.result_valid, 0);
    chk("t6_ign_max", if_a.max_len, 0);
    do_start(2'b01);
    stream(8'b1111_1111, 8);
    chk("t6_rec_done", if_a.done, 1);
    chk("t6_rec_max", if_a.max_len, 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
